uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, giving the line bit rate.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port data, output, 8 bits: last correctly received byte.
REQ-007 SHALL have port data_valid, output, 1 bit: one-cycle pulse when data updates.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s only.
REQ-011 SHALL define BAUD_TICK = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults) and HALF_TICK = BAUD_TICK/2 (217).
REQ-012 SHALL use a 16-bit baud counter, a 3-bit bit index and an 8-bit shift register.
REQ-013 SHALL implement states IDLE, START, DATA and STOP.
REQ-014 IDLE: when rx_s==0 and the line is armed, SHALL go to START and clear the counter.
REQ-015 START: at counter==HALF_TICK-1, rx_s==0 SHALL go to DATA with counter cleared; rx_s==1 SHALL count as a false start and return to IDLE with no pulse.
REQ-016 DATA: at each counter==BAUD_TICK-1, SHALL shift rx_s in LSB-first and clear the counter; after the 8th bit SHALL go to STOP.
REQ-017 STOP: at counter==BAUD_TICK-1, SHALL sample rx_s and return to IDLE in the same cycle, i.e. at mid-stop-bit, so back-to-back frames are accepted.
REQ-018 On a stop sample of 1, SHALL load data from the shift register and pulse data_valid on the following cycle.
REQ-019 data SHALL hold its value until the next valid byte; there is no backpressure, and an unread byte is silently overwritten.
REQ-020 data_valid and frame_err SHALL never be asserted in the same cycle.
REQ-021 On a stop sample of 0, SHALL disarm IDLE; IDLE SHALL re-arm only after rx_s has been observed at 1, so a held-low break yields one error, not repeated frames.
REQ-022 SHALL take no action on rx edges while in the START, DATA or STOP states.

Reset
REQ-023 On rst_n low, SHALL asynchronously set: state IDLE, armed 1, data 0x00, data_valid 0, frame_err 0, busy 0, counters 0, shift 0x00, synchronizer flops 1.
REQ-024 Reset mid-frame SHALL abandon the frame with no pulse; reception SHALL resume on the next falling edge after release.

Configuration
REQ-025 SHALL use macro UART_RX_FRAME_CHECK_EN to select stop-bit checking.
REQ-026 With UART_RX_FRAME_CHECK_EN defined, a bad stop bit SHALL pulse frame_err, leave data unchanged, and give no data_valid.
REQ-027 Without UART_RX_FRAME_CHECK_EN, SHALL tie frame_err to 0, always load data with a data_valid pulse regardless of the stop sample, and keep the re-arm rule of REQ-021.

Structure
REQ-028 SHALL take the CLK_FREQ/BAUD_RATE defaults, the BAUD_TICK/HALF_TICK derivation and the state encoding from shared package uart_pkg, also used by the transmitter.
REQ-029 SHALL instantiate the synchronizer as sub-module uart_sync2 (2-flop, reset value 1).

Verification
REQ-030 SHALL verify: frame 0xA5 at 115200 -> exactly one data_valid, data==0xA5, about 9.5 bit times (~4123 clk) after the start edge.
REQ-031 SHALL verify: back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three data_valid pulses in order, no frame_err.
REQ-032 SHALL verify: a 100-clk low glitch on idle rx -> false start, no pulse, busy low again by 250 clk.
REQ-033 SHALL verify: frame 0x55 with stop bit forced 0 -> frame_err pulse, data keeps previous value (with macro); data_valid with data==0x55 (without macro).
REQ-034 SHALL verify: rx held low for 30 bit times, then high, then frame 0x81 -> exactly one frame_err, then data==0x81.
REQ-035 SHALL verify: rst_n asserted at bit 4 of 0xC3, then released, then frame 0x12 -> no pulse for 0xC3, data==0x12.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default clock/baud, bit-timing derivation and
// receiver state encoding, common to the receiver and transmitter.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 50_000_000;
  localparam int unsigned BAUD_RATE_DEF = 115200;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned baud_tick(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned half_tick(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
    return baud_tick(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so reset release never looks like a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling at mid-bit. Define UART_RX_FRAME_CHECK_EN to
// reject frames with a bad stop bit (frame_err pulse, data unchanged).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BAUD_TICK = baud_tick(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_TICK = half_tick(CLK_FREQ, BAUD_RATE);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_TICK - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICK - 1);

  logic             rx_s;
  uart_state_e      state_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             data_valid_q;
`ifdef UART_RX_FRAME_CHECK_EN
  logic             frame_err_q;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // NOTE: every register here is updated with <= so all reads in this block
  // see last cycle's values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      frame_err_q  <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      frame_err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // A bad stop bit disarms; the line must return high before the
          // next falling edge is taken as a start.
          if (!armed_q) begin
            if (rx_s) armed_q <= 1'b1;
          end else if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BAUD_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s) begin
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
            end else begin
              armed_q <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
              frame_err_q  <= 1'b1;
`else
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RX_FRAME_CHECK_EN
  assign frame_err  = frame_err_q;
`else
  assign frame_err  = 1'b0;
`endif

endmodule
